// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// Optional skid buffer in pipe_stage_reg is selected with PIPE_SKID_EN.
package pipe_pkg;

   localparam int unsigned PIPE_ADDR_W = 5;
   localparam int unsigned PIPE_DATA_W = 32;
   localparam int unsigned PIPE_PC_W   = 32;

   // Payload layout at the default widths; the flat vector inside
   // pipe_stage_reg uses the same field order (regWAddr in the MSBs).
   typedef struct packed {
      logic [PIPE_ADDR_W-1:0] regWAddr;
      logic [PIPE_DATA_W-1:0] result;
      logic [PIPE_DATA_W-1:0] readData;
      logic [PIPE_PC_W-1:0]   pc;
   } pipe_payload_t;

   // Write address presented during a bubble: register x0, a no-op write.
   localparam int unsigned PIPE_X0 = 0;

   function automatic int unsigned pipe_payload_w(input int unsigned addr_w,
                                                  input int unsigned data_w,
                                                  input int unsigned pc_w);
      return addr_w + 2 * data_w + pc_w;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single skid entry plus its valid bit, generic over payload width.
// Flush dominates push, push dominates pop.
module pipe_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_d, valid_q;
   logic [W-1:0] data_d, data_q;

   // Next-state for the skid entry.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (push) begin
         valid_d = 1'b1;
         data_d  = push_data;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   // Skid entry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous
// flush and bubble gating of the write address.
// Define PIPE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned     ADDR_W   = 5,
   parameter int unsigned     DATA_W   = 32,
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_regWAddr,
   input  logic [DATA_W-1:0] in_result,
   input  logic [DATA_W-1:0] in_readData,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] data_regWAddr,
   output logic [DATA_W-1:0] data_result,
   output logic [DATA_W-1:0] data_readData,
   output logic [PC_W-1:0]   data_pc
);

   localparam int unsigned PAY_W = pipe_payload_w(ADDR_W, DATA_W, PC_W);
   localparam logic [PAY_W-1:0] PAY_RST = {{ADDR_W{1'b0}}, {DATA_W{1'b0}},
                                           {DATA_W{1'b0}}, RESET_PC};

   logic [PAY_W-1:0] pay_in;
   logic [PAY_W-1:0] main_d, main_q;
   logic             main_valid_d, main_valid_q;
   logic             up_xfer;
   logic             down_xfer;

   assign pay_in    = {in_regWAddr, in_result, in_readData, in_pc};
   assign up_xfer   = in_valid & in_ready;
   assign down_xfer = main_valid_q & out_ready;

`ifdef PIPE_SKID_EN

   logic             skid_valid;
   logic [PAY_W-1:0] skid_data;
   logic             skid_push;
   logic             skid_pop;
   logic             in_ready_d, in_ready_q;

   // An accepted entry that cannot enter main (main full and staying) parks
   // in the skid; in_ready is low whenever the skid is occupied, so a push
   // never overwrites a held skid entry.
   assign skid_push = up_xfer & main_valid_q & ~down_xfer;
   assign skid_pop  = skid_valid & down_xfer;

   pipe_skid_buf #(
      .W (PAY_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (flush),
      .push      (skid_push),
      .pop       (skid_pop),
      .push_data (pay_in),
      .valid     (skid_valid),
      .data      (skid_data)
   );

   // Main register and registered ready; skid entry always drains first.
   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      in_ready_d   = in_ready_q;
      if (flush) begin
         main_valid_d = 1'b0;
         in_ready_d   = 1'b1;
      end else if (skid_valid) begin
         if (down_xfer) begin
            main_d     = skid_data;
            in_ready_d = 1'b1;
         end
      end else if (up_xfer && (!main_valid_q || down_xfer)) begin
         main_valid_d = 1'b1;
         main_d       = pay_in;
      end else if (up_xfer) begin
         in_ready_d = 1'b0;
      end else if (down_xfer) begin
         main_valid_d = 1'b0;
      end
   end

   // Registered upstream ready breaks the combinational ready chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;

`else

   assign in_ready = out_ready | ~main_valid_q;

   // Single-entry main register: load on accept, drain on downstream take.
   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (up_xfer) begin
         main_valid_d = 1'b1;
         main_d       = pay_in;
      end else if (down_xfer) begin
         main_valid_d = 1'b0;
      end
   end

`endif

   // Main payload and valid flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_valid_q <= 1'b0;
         main_q       <= PAY_RST;
      end else begin
         main_valid_q <= main_valid_d;
         main_q       <= main_d;
      end
   end

   assign out_valid     = main_valid_q;
   assign data_regWAddr = main_valid_q ? main_q[PAY_W-1 -: ADDR_W] : ADDR_W'(PIPE_X0);
   assign data_result   = main_q[PC_W+DATA_W +: DATA_W];
   assign data_readData = main_q[PC_W +: DATA_W];
   assign data_pc       = main_q[PC_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations adapt to PIPE_SKID_EN.
module tb_pipe_stage_reg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned PC_W   = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0F00;

`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_regWAddr;
   logic [DATA_W-1:0] in_result;
   logic [DATA_W-1:0] in_readData;
   logic [PC_W-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] data_regWAddr;
   logic [DATA_W-1:0] data_result;
   logic [DATA_W-1:0] data_readData;
   logic [PC_W-1:0]   data_pc;

   int checks   = 0;
   int failures = 0;
   int k_src    = 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_stage_reg #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .PC_W     (PC_W),
      .RESET_PC (RST_PC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_regWAddr   (in_regWAddr),
      .in_result     (in_result),
      .in_readData   (in_readData),
      .in_pc         (in_pc),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .data_regWAddr (data_regWAddr),
      .data_result   (data_result),
      .data_readData (data_readData),
      .data_pc       (data_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input int k);
      in_regWAddr = 5'(k);
      in_result   = 32'h1000 + 32'(k);
      in_readData = 32'h2000 + 32'(k);
      in_pc       = 32'h300 + 32'(4 * k);
   endtask

   // One cycle of a source that advances only on an accepted transfer.
   task automatic stall_step(input string tag, input logic ordy, input logic vld,
                             input logic exp_rdy, input logic exp_ov, input int exp_k);
      logic acc;
      out_ready = ordy;
      in_valid  = vld;
      present(k_src);
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
      acc = in_valid & in_ready;
      tick();
      if (acc) k_src++;
      check({tag, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
      check({tag, "_addr"}, 32'(data_regWAddr), exp_ov ? 32'(5'(exp_k)) : 32'd0);
      if (exp_ov) begin
         check({tag, "_pc"}, data_pc, 32'h300 + 32'(4 * exp_k));
         check({tag, "_result"}, data_result, 32'h1000 + 32'(exp_k));
      end
   endtask

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      in_regWAddr = '0;
      in_result   = '0;
      in_readData = '0;
      in_pc       = '0;
      flush       = 1'b0;
      out_ready   = 1'b0;

      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_addr", 32'(data_regWAddr), 32'd0);
      check("rst_result", data_result, 32'd0);
      check("rst_readData", data_readData, 32'd0);
      check("rst_pc", data_pc, RST_PC);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      tick();

      // back-to-back streaming, one entry per cycle
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         present(i);
         in_result = 32'(i * 16);
         #1;
         check("stream_in_ready", 32'(in_ready), 32'd1);
         tick();
         check("stream_out_valid", 32'(out_valid), 32'd1);
         check("stream_addr", 32'(data_regWAddr), 32'(i));
         check("stream_result", data_result, 32'(i * 16));
         check("stream_pc", data_pc, 32'h300 + 32'(4 * i));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drain_valid", 32'(out_valid), 32'd0);

      // bubble gating of the write address
      in_valid    = 1'b1;
      in_regWAddr = 5'd7;
      in_result   = 32'h77;
      tick();
      check("bubble_load_valid", 32'(out_valid), 32'd1);
      check("bubble_load_addr", 32'(data_regWAddr), 32'd7);
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bubble_valid", 32'(out_valid), 32'd0);
         check("bubble_addr", 32'(data_regWAddr), 32'd0);
      end

      // stall for 3 cycles in the middle of a stream
      k_src = 1;
      stall_step("stall_a", 1'b1, 1'b1, 1'b1, 1'b1, 1);
      stall_step("stall_b", 1'b0, 1'b1, SKID ? 1'b1 : 1'b0, 1'b1, 1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      #1;
      check("stall_ready_comb", 32'(in_ready), SKID ? 32'd0 : 32'd1);
      out_ready = 1'b0;
      #1;
      check("stall_ready_comb_low", 32'(in_ready), 32'd0);
      stall_step("stall_c", 1'b0, 1'b1, 1'b0, 1'b1, 1);
      stall_step("stall_d", 1'b0, 1'b1, 1'b0, 1'b1, 1);
      stall_step("stall_e", 1'b1, 1'b1, SKID ? 1'b0 : 1'b1, 1'b1, 2);
      stall_step("stall_f", 1'b1, 1'b1, 1'b1, 1'b1, 3);
      stall_step("stall_g", 1'b1, 1'b0, 1'b1, 1'b0, 0);
      check("stall_accept_count", 32'(k_src), 32'd4);

      // flush with held entries and a concurrent upstream offer
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_regWAddr = 5'd5;
      in_result   = 32'h55;
      in_readData = 32'h0;
      in_pc       = 32'h100;
      tick();
      check("flush_main_valid", 32'(out_valid), 32'd1);
      check("flush_main_pc", data_pc, 32'h100);
      in_regWAddr = 5'd6;
      in_pc       = 32'h104;
      #1;
      check("flush_skid_ready", 32'(in_ready), SKID ? 32'd1 : 32'd0);
      tick();
      check("flush_hold_pc", data_pc, 32'h100);
      flush       = 1'b1;
      in_regWAddr = 5'd8;
      in_pc       = 32'h108;
      #1;
      check("flush_cycle_ready", 32'(in_ready), 32'd0);
      tick();
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_addr", 32'(data_regWAddr), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("flush_after_valid", 32'(out_valid), 32'd0);
         check("flush_no_108", 32'(data_pc == 32'h108), 32'd0);
      end

      // asynchronous reset in the middle of a transfer
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_regWAddr = 5'd9;
      in_result   = 32'h99;
      in_readData = 32'h999;
      in_pc       = 32'h400;
      tick();
      check("mid_load_addr", 32'(data_regWAddr), 32'd9);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_addr", 32'(data_regWAddr), 32'd0);
      check("mid_rst_result", data_result, 32'd0);
      check("mid_rst_readData", data_readData, 32'd0);
      check("mid_rst_pc", data_pc, RST_PC);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      #2;
      reset       = 1'b1;
      out_ready   = 1'b1;
      in_regWAddr = 5'd3;
      in_result   = 32'h33;
      in_readData = 32'h333;
      in_pc       = 32'h500;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_addr", 32'(data_regWAddr), 32'd3);
      check("post_rst_readData", data_readData, 32'h333);
      check("post_rst_pc", data_pc, 32'h500);
      in_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
